// File: rtl/usb_tx_pkg.sv
// USB TX packet sequencer shared types and constants.
// Packet kinds, FSM states, CRC polynomials/seeds, SYNC pattern.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    KIND_TOKEN  = 2'd0,
    KIND_DATA   = 2'd1,
    KIND_HSHAKE = 2'd2
  } pkt_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_CRC5,
    ST_CRC16
  } tx_state_t;

  localparam logic [4:0]  CRC5_POLY    = 5'h05;
  localparam logic [4:0]  CRC5_INIT    = 5'h1F;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [7:0]  SYNC_PATTERN = 8'h80;

  // PID byte carries the check nibble in the upper half.
  function automatic logic [7:0] pid_byte(input logic [3:0] p);
    return {~p, p};
  endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial CRC register, MSB-out form, one input bit per enable.
// init has priority and reloads the seed.
module usb_crc_lfsr #(
  parameter int           W    = 5,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] INIT = '1
) (
  input  logic         clk,
  input  logic         en,
  input  logic         init,
  input  logic         din,
  output logic [W-1:0] residue
);

  logic [W-1:0] r_crc;
  logic         w_fb;

  assign w_fb    = din ^ r_crc[W-1];
  assign residue = r_crc;

  // Seed on init, otherwise advance one bit per enable.
  always_ff @(posedge clk) begin
    if (init) begin
      r_crc <= INIT;
    end else if (en) begin
      r_crc <= {r_crc[W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/usb_tx_pkt_sequencer.sv
// USB TX packet sequencer: token/data/handshake to serial bits.
// Define USB_TX_SYNC_GEN_EN to emit the SYNC byte in this block.
module usb_tx_pkt_sequencer
  import usb_tx_pkg::*;
#(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  pkt_kind_t  req_kind,
  input  logic [3:0] req_pid,
  input  logic [6:0] req_addr,
  input  logic [3:0] req_endp,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
  input  logic       pl_last,
  output logic       pl_ready,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_bit,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       busy,
  output logic       err_len
);

  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(MAX_BYTES - 1);

  tx_state_t   r_state, w_state_nxt;
  logic [10:0] r_sh, w_sh_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_have, w_have_nxt;
  logic        r_last, w_last_nxt;
  logic [BW-1:0] r_bytes, w_bytes_nxt;
  pkt_kind_t   r_kind;
  logic [3:0]  r_pid;
  logic [6:0]  r_addr;
  logic [3:0]  r_endp;
  logic        w_acc, w_init, w_cap;
  logic        w_c5_en, w_c16_en;
  logic [4:0]  w_crc5;
  logic [15:0] w_crc16;
  logic [2:0]  w_i5;
  logic [3:0]  w_i16;

  assign w_init = rst | w_acc;
  assign w_cap  = (r_bytes == LAST_IDX);
  assign w_i5   = 3'd4 - r_cnt[2:0];
  assign w_i16  = 4'd15 - r_cnt;

  usb_crc_lfsr #(.W(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk(clk), .en(w_c5_en), .init(w_init),
    .din(r_sh[0]), .residue(w_crc5)
  );

  usb_crc_lfsr #(.W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk(clk), .en(w_c16_en), .init(w_init),
    .din(r_sh[0]), .residue(w_crc16)
  );

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_have  <= 1'b0;
      r_last  <= 1'b0;
      r_bytes <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_cnt   <= w_cnt_nxt;
      r_have  <= w_have_nxt;
      r_last  <= w_last_nxt;
      r_bytes <= w_bytes_nxt;
    end
  end

  // Request fields captured on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind <= KIND_TOKEN;
      r_pid  <= '0;
      r_addr <= '0;
      r_endp <= '0;
    end else if (w_acc) begin
      r_kind <= req_kind;
      r_pid  <= req_pid;
      r_addr <= req_addr;
      r_endp <= req_endp;
    end
  end

  // Next state, bit serialisation and handshakes; all quiet in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_have_nxt  = r_have;
    w_last_nxt  = r_last;
    w_bytes_nxt = r_bytes;
    w_acc       = 1'b0;
    w_c5_en     = 1'b0;
    w_c16_en    = 1'b0;
    req_ready   = 1'b0;
    pl_ready    = 1'b0;
    tx_valid    = 1'b0;
    tx_bit      = 1'b0;
    tx_sop      = 1'b0;
    tx_eop      = 1'b0;
    err_len     = 1'b0;
    busy        = !rst && (r_state != ST_IDLE);
    if (!rst) begin
      unique case (r_state)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            w_acc     = 1'b1;
            w_cnt_nxt = '0;
`ifdef USB_TX_SYNC_GEN_EN
            w_sh_nxt    = {3'b0, SYNC_PATTERN};
            w_state_nxt = ST_SYNC;
`else
            w_sh_nxt    = {3'b0, pid_byte(req_pid)};
            w_state_nxt = ST_PID;
`endif
          end
        end
`ifdef USB_TX_SYNC_GEN_EN
        ST_SYNC: begin
          tx_valid = 1'b1;
          tx_bit   = r_sh[0];
          tx_sop   = (r_cnt == 4'd0);
          if (tx_ready) begin
            w_sh_nxt  = r_sh >> 1;
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_sh_nxt    = {3'b0, pid_byte(r_pid)};
              w_cnt_nxt   = '0;
              w_state_nxt = ST_PID;
            end
          end
        end
`endif
        ST_PID: begin
          tx_valid = 1'b1;
          tx_bit   = r_sh[0];
`ifndef USB_TX_SYNC_GEN_EN
          tx_sop   = (r_cnt == 4'd0);
`endif
          tx_eop   = (r_cnt == 4'd7) && (r_kind == KIND_HSHAKE);
          if (tx_ready) begin
            w_sh_nxt  = r_sh >> 1;
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt = '0;
              if (r_kind == KIND_TOKEN) begin
                w_sh_nxt    = {r_endp, r_addr};
                w_state_nxt = ST_TOKEN;
              end else if (r_kind == KIND_DATA) begin
                w_have_nxt  = 1'b0;
                w_bytes_nxt = '0;
                w_state_nxt = ST_DATA;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
          end
        end
        ST_TOKEN: begin
          tx_valid = 1'b1;
          tx_bit   = r_sh[0];
          if (tx_ready) begin
            w_c5_en   = 1'b1;
            w_sh_nxt  = r_sh >> 1;
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd10) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_CRC5;
            end
          end
        end
        ST_CRC5: begin
          tx_valid = 1'b1;
          tx_bit   = ~w_crc5[w_i5];
          tx_eop   = (r_cnt == 4'd4);
          if (tx_ready) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd4) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (r_have) begin
            tx_valid = 1'b1;
            tx_bit   = r_sh[0];
            if (tx_ready) begin
              w_c16_en  = 1'b1;
              w_sh_nxt  = r_sh >> 1;
              w_cnt_nxt = r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                w_cnt_nxt  = '0;
                w_have_nxt = 1'b0;
                if (r_last) begin
                  w_state_nxt = ST_CRC16;
                end
              end
            end
          end else if (pl_valid) begin
            pl_ready    = 1'b1;
            err_len     = w_cap && !pl_last;
            w_sh_nxt    = {3'b0, pl_data};
            w_cnt_nxt   = '0;
            w_have_nxt  = 1'b1;
            w_last_nxt  = pl_last || w_cap;
            w_bytes_nxt = r_bytes + BW'(1);
          end else if (pl_last && (r_bytes == '0)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_CRC16;
          end
        end
        ST_CRC16: begin
          tx_valid = 1'b1;
          tx_bit   = ~w_crc16[w_i16];
          tx_eop   = (r_cnt == 4'd15);
          if (tx_ready) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_pkt_sequencer.sv
// Directed bench for usb_tx_pkt_sequencer (MAX_BYTES=4).
// Works with and without USB_TX_SYNC_GEN_EN.
module tb_usb_tx_pkt_sequencer;
  import usb_tx_pkg::*;

`ifdef USB_TX_SYNC_GEN_EN
  localparam int SY = 8;
`else
  localparam int SY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  pkt_kind_t  req_kind = KIND_TOKEN;
  logic [3:0] req_pid = '0;
  logic [6:0] req_addr = '0;
  logic [3:0] req_endp = '0;
  logic       pl_valid = 1'b0;
  logic [7:0] pl_data = '0;
  logic       pl_last = 1'b0;
  logic       pl_ready;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       tx_bit, tx_sop, tx_eop, busy, err_len;

  int n_tests = 0;
  int n_fail  = 0;

  bit  cap_bit[$];
  bit  cap_sop[$];
  bit  cap_eop[$];
  bit  exp_q[$];
  int  n_plr = 0;
  int  n_err = 0;
  int  hold_bad = 0;
  bit  rdy_rand = 0;
  int  fd_n = 0, fd_base = 0, fd_idx = 0;
  bit  fd_mark = 0, fd_gaps = 0;

  usb_tx_pkt_sequencer #(.MAX_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_pid(req_pid),
    .req_addr(req_addr), .req_endp(req_endp),
    .pl_valid(pl_valid), .pl_data(pl_data),
    .pl_last(pl_last), .pl_ready(pl_ready),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_bit(tx_bit), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: capture transfers, count pulses, check hold while stalled.
  logic [2:0] hold_v;
  bit         hold_p = 0;
  always @(negedge clk) begin
    if (rst) begin
      hold_p = 0;
    end else begin
      if (hold_p && tx_valid && hold_v != {tx_bit, tx_sop, tx_eop})
        hold_bad++;
      hold_p = tx_valid && !tx_ready;
      hold_v = {tx_bit, tx_sop, tx_eop};
      if (tx_valid && tx_ready) begin
        cap_bit.push_back(tx_bit);
        cap_sop.push_back(tx_sop);
        cap_eop.push_back(tx_eop);
      end
      if (pl_ready) n_plr++;
      if (err_len) n_err++;
    end
  end

  // Downstream ready: always 1 or random.
  always @(posedge clk) begin
    #1;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Payload source: bytes 0,1,2,... advanced by pl_ready.
  always @(posedge clk) begin
    #1;
    fd_idx   = n_plr - fd_base;
    pl_valid = (fd_idx < fd_n) &&
               (!fd_gaps || ($urandom_range(0, 3) != 0));
    pl_data  = 8'(fd_idx);
    if (fd_n == 0) pl_last = fd_mark;
    else pl_last = pl_valid && fd_mark && (fd_idx == fd_n - 1);
  end

  task automatic exp_start();
    exp_q.delete();
    if (SY != 0) exp_byte(8'h80);
  endtask

  task automatic exp_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
  endtask

  // Reflected CRC16 (0xA001) over bytes 0..n-1, sent LSB first.
  task automatic exp_crc16(input int n);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      b = 8'(k);
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[j]) c = (c >> 1) ^ 16'hA001;
        else c = c >> 1;
      end
    end
    c = ~c;
    for (int i = 0; i < 16; i++) exp_q.push_back(c[i]);
  endtask

  task automatic run_pkt(input string tag, input pkt_kind_t k,
                         input logic [3:0] pid);
    int  base, t;
    bit  seen;
    logic [127:0] g, e, gs, es, ge, ee;
    base      = cap_bit.size();
    req_valid = 1'b1;
    req_kind  = k;
    req_pid   = pid;
    req_addr  = '0;
    req_endp  = '0;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_acc"}, 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    seen = 0;
    t = 0;
    while (!seen && t < 3000) begin
      @(negedge clk);
      t++;
      seen = tx_valid && tx_ready && tx_eop;
    end
    chk({tag, "_eop_seen"}, 128'(seen), 128'(1));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy_off"}, 128'(busy), 128'(0));
    chk({tag, "_rdy_after"}, 128'(req_ready), 128'(1));
    g = '0; e = '0; gs = '0; es = '0; ge = '0; ee = '0;
    for (int i = 0; i < 128; i++) begin
      if (base + i < cap_bit.size()) begin
        g[i]  = cap_bit[base + i];
        gs[i] = cap_sop[base + i];
        ge[i] = cap_eop[base + i];
      end
      if (i < exp_q.size()) e[i] = exp_q[i];
    end
    es[0] = 1'b1;
    ee[exp_q.size() - 1] = 1'b1;
    chk({tag, "_len"}, 128'(cap_bit.size() - base),
        128'(exp_q.size()));
    chk({tag, "_bits"}, g, e);
    chk({tag, "_sop"}, gs, es);
    chk({tag, "_eop"}, ge, ee);
  endtask

  task automatic exp_token0();
    exp_start();
    exp_byte(8'h2D);
    exp_byte(8'h00);
    exp_byte(8'h10);
  endtask

  initial begin
    int base_p, base_e, k, t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_tx_valid", 128'(tx_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 128'(req_ready), 128'(1));

    exp_token0();
    run_pkt("setup", KIND_TOKEN, 4'hD);

    fd_base = n_plr; fd_n = 0; fd_mark = 1; fd_gaps = 0;
    base_p = n_plr;
    exp_start();
    exp_byte(8'hC3);
    exp_crc16(0);
    run_pkt("zlp", KIND_DATA, 4'h3);
    chk("zlp_plr", 128'(n_plr - base_p), 128'(0));

    fd_base = n_plr; fd_n = 4; fd_mark = 1; fd_gaps = 1;
    rdy_rand = 1;
    base_p = n_plr; base_e = n_err;
    exp_start();
    exp_byte(8'hC3);
    for (int i = 0; i < 4; i++) exp_byte(8'(i));
    exp_crc16(4);
    run_pkt("data4", KIND_DATA, 4'h3);
    chk("data4_plr", 128'(n_plr - base_p), 128'(4));
    chk("data4_err", 128'(n_err - base_e), 128'(0));
    rdy_rand = 0;
    fd_n = 0; fd_mark = 0; fd_gaps = 0;

    exp_start();
    exp_byte(8'hD2);
    run_pkt("ack", KIND_HSHAKE, 4'h2);
    exp_token0();
    run_pkt("b2b_tok", KIND_TOKEN, 4'hD);

    fd_base = n_plr; fd_n = 6; fd_mark = 0;
    base_p = n_plr; base_e = n_err;
    exp_start();
    exp_byte(8'hC3);
    for (int i = 0; i < 4; i++) exp_byte(8'(i));
    exp_crc16(4);
    run_pkt("trunc", KIND_DATA, 4'h3);
    chk("trunc_plr", 128'(n_plr - base_p), 128'(4));
    chk("trunc_err", 128'(n_err - base_e), 128'(1));
    fd_n = 0;

    req_valid = 1'b1;
    req_kind  = KIND_TOKEN;
    req_pid   = 4'hD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    k = 0;
    t = 0;
    while (k < SY + 3 && t < 500) begin
      @(negedge clk);
      t++;
      if (tx_valid && tx_ready) k++;
    end
    chk("mid_reach", 128'(k), 128'(SY + 3));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_txv", 128'(tx_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_after_txv", 128'(tx_valid), 128'(0));
    chk("mid_after_busy", 128'(busy), 128'(0));
    chk("mid_after_rdy", 128'(req_ready), 128'(1));
    exp_token0();
    run_pkt("tok_after_rst", KIND_TOKEN, 4'hD);

    chk("hold_stable", 128'(hold_bad), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule
